// File: rtl/matmul_output_drain_pkg.sv
// Shared types and sizing helpers for the output-matrix drain.
// ELEMS/ROW_W/COL_W describe the default 4x4 geometry; instances derive their own via idx_w.
package matmul_drain_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      STREAM  = 2'd2,
      DONE    = 2'd3
   } drain_state_t;

   // Index width for a dimension of n entries, never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int DEF_ROWS = 4;
   localparam int DEF_COLS = 4;
   localparam int ELEMS    = DEF_ROWS * DEF_COLS;
   localparam int ROW_W    = idx_w(DEF_ROWS);
   localparam int COL_W    = idx_w(DEF_COLS);

endpackage

// File: rtl/matmul_output_drain_index_counter.sv
// Row-major row/col walker: advances on en, wraps col into row, clears synchronously.
// is_last flags the final (ROWS-1, COLS-1) position.
module drain_index_counter
   import matmul_drain_pkg::*;
#(
   parameter int ROWS = DEF_ROWS,
   parameter int COLS = DEF_COLS,
   parameter int RW   = idx_w(ROWS),
   parameter int CW   = idx_w(COLS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          en,
   output logic [RW-1:0] row,
   output logic [CW-1:0] col,
   output logic          is_last
);

   localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
   localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         row <= '0;
         col <= '0;
      end else if (en) begin
         if (col == COL_MAX) begin
            col <= '0;
            row <= (row == ROW_MAX) ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   assign is_last = (row == ROW_MAX) && (col == COL_MAX);

endmodule

// File: rtl/matmul_output_drain.sv
// Snapshots a finished output tile and streams it row-major over valid/ready,
// then pulses done/clear_req so upstream accumulators can be zeroed.
module matmul_output_drain
   import matmul_drain_pkg::*;
#(
   parameter int ROWS      = DEF_ROWS,
   parameter int COLS      = DEF_COLS,
   parameter int WORD_SIZE = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic [ROWS*COLS*WORD_SIZE-1:0] matrix_flat,
   input  logic                           out_ready,
   output logic                           out_valid,
   output logic [WORD_SIZE-1:0]           out_data,
   output logic [idx_w(ROWS)-1:0]         out_row,
   output logic [idx_w(COLS)-1:0]         out_col,
   output logic                           out_last,
   output logic                           busy,
   output logic                           done,
   output logic                           clear_req
);

   localparam int N_ELEMS = ROWS * COLS;
   localparam int IDX_W   = idx_w(N_ELEMS);

   // Handshake: a word transfers on a rising edge where out_valid && out_ready;
   // while out_valid is high and out_ready low, data/row/col/last hold stable.
   drain_state_t         state;
   logic [WORD_SIZE-1:0] snap [N_ELEMS];
   logic                 handshake;
   logic                 is_last;
   logic [IDX_W-1:0]     next_idx;

   assign handshake = out_valid & out_ready;
   assign out_last  = is_last & out_valid;
   // Row-major order makes the following element simply linear index + 1.
   assign next_idx  = IDX_W'(int'(out_row) * COLS + int'(out_col) + 1);

   drain_index_counter #(
      .ROWS (ROWS),
      .COLS (COLS),
      .RW   (idx_w(ROWS)),
      .CW   (idx_w(COLS))
   ) u_index (
      .clk     (clk),
      .rst     (rst),
      .clear   (state == DONE),
      .en      (handshake & ~is_last),
      .row     (out_row),
      .col     (out_col),
      .is_last (is_last)
   );

   always_ff @(posedge clk) begin
      if (state == IDLE && start) begin
         for (int i = 0; i < N_ELEMS; i++) begin
            snap[i] <= matrix_flat[i*WORD_SIZE +: WORD_SIZE];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         out_data  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         clear_req <= 1'b0;
      end else begin
         done      <= 1'b0;
         clear_req <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  busy  <= 1'b1;
                  state <= CAPTURE;
               end
            end
            CAPTURE: begin
               out_data  <= snap[0];
               out_valid <= 1'b1;
               state     <= STREAM;
            end
            STREAM: begin
               if (handshake) begin
                  if (is_last) begin
                     out_valid <= 1'b0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     clear_req <= 1'b1;
                     state     <= DONE;
                  end else begin
                     out_data <= snap[next_idx];
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_matmul_output_drain.sv
// Bench for matmul_output_drain: table of tile scenarios on a 4x4 instance plus a 2x3 instance sequence,
// checked against a row-major expected queue built from the matrix captured at start.
module tb_matmul_output_drain;
   import matmul_drain_pkg::*;

   localparam int R     = 4;
   localparam int C     = 4;
   localparam int W     = 16;
   localparam int R2    = 2;
   localparam int C2    = 3;
   localparam int EXP_W = 1 + 2 + 2 + W;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           start = 1'b0;
   logic           out_ready = 1'b0;
   logic [R*C*W-1:0] matrix_flat = '0;
   logic           out_valid, out_last, busy, done, clear_req;
   logic [W-1:0]   out_data;
   logic [1:0]     out_row, out_col;

   logic           start2 = 1'b0;
   logic           out_ready2 = 1'b0;
   logic [R2*C2*W-1:0] matrix_flat2 = '0;
   logic           out_valid2, out_last2, busy2, done2, clear_req2;
   logic [W-1:0]   out_data2;
   logic [0:0]     out_row2;
   logic [1:0]     out_col2;

   always #5 clk = ~clk;

   matmul_output_drain #(.ROWS(R), .COLS(C), .WORD_SIZE(W)) dut (
      .clk(clk), .rst(rst), .start(start), .matrix_flat(matrix_flat),
      .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
      .out_row(out_row), .out_col(out_col), .out_last(out_last),
      .busy(busy), .done(done), .clear_req(clear_req)
   );

   matmul_output_drain #(.ROWS(R2), .COLS(C2), .WORD_SIZE(W)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .matrix_flat(matrix_flat2),
      .out_ready(out_ready2), .out_valid(out_valid2), .out_data(out_data2),
      .out_row(out_row2), .out_col(out_col2), .out_last(out_last2),
      .busy(busy2), .done(done2), .clear_req(clear_req2)
   );

   int checks = 0;
   int failures = 0;
   logic [EXP_W-1:0] exp_q[$];
   logic [W-1:0]     m [R][C];

   typedef struct {
      int mode;          // 0 ready always, 1 toggle 1/0, 2 random
      bit rand_data;
      bit poison;
      int restrike_at;   // pulse start after this many words (0 = never)
      int abort_at;      // reset after this many words (0 = never)
      int exp_words;
      int exp_dones;
      int exp_done_cyc;  // -1 = not checked
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic load_matrix(input bit rnd);
      for (int r = 0; r < R; r++)
         for (int c = 0; c < C; c++) begin
            m[r][c] = rnd ? W'($urandom) : W'(16 * r + c);
            matrix_flat[(r*C+c)*W +: W] = m[r][c];
         end
   endtask

   task automatic build_expected();
      exp_q.delete();
      for (int r = 0; r < R; r++)
         for (int c = 0; c < C; c++)
            exp_q.push_back({(r == R-1) && (c == C-1), 2'(r), 2'(c), m[r][c]});
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_valid"}, out_valid, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_clear_req"}, clear_req, 0);
      chk({tag, "_last"}, out_last, 0);
      chk({tag, "_data"}, out_data, 0);
      chk({tag, "_row"}, out_row, 0);
      chk({tag, "_col"}, out_col, 0);
   endtask

   task automatic run_tile(input int mode, input bit rand_data, input bit poison,
                           input int restrike_at, input int abort_at,
                           output int words, output int dones, output int done_cyc);
      logic [EXP_W-1:0] e;
      bit exp_done = 0;
      bit finished = 0;
      bit tog = 1;
      int abort_stage = 0;
      int cyc = 0;
      words = 0;
      dones = 0;
      done_cyc = -1;
      load_matrix(rand_data);
      build_expected();
      @(negedge clk);
      start = 1'b1;
      out_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      chk("capture_valid", out_valid, 0);
      chk("capture_busy", busy, 1);
      if (poison) matrix_flat = '1;
      while (!finished && cyc < 200) begin
         @(negedge clk);
         cyc++;
         start = 1'b0;
         if (abort_stage == 2) begin
            check_reset_outputs("abort");
            rst = 1'b0;
            finished = 1;
         end else if (abort_stage == 1) begin
            rst = 1'b1;
            out_ready = 1'b0;
            abort_stage = 2;
         end else begin
            chk("done", done, exp_done);
            chk("clear_req", clear_req, exp_done);
            if (done) begin
               dones++;
               done_cyc = cyc;
            end
            if (exp_done) begin
               finished = 1;
            end else begin
               case (mode)
                  0: out_ready = 1'b1;
                  1: begin out_ready = tog; tog = !tog; end
                  default: out_ready = ($urandom_range(0, 3) != 0);
               endcase
               if (!out_valid) begin
                  chk("stream_valid", out_valid, 1);
               end else if (exp_q.size() == 0) begin
                  chk("extra_word", out_valid, 0);
                  finished = 1;
               end else begin
                  e = exp_q[0];
                  chk("out_data", out_data, e[W-1:0]);
                  chk("out_col", out_col, e[W+1:W]);
                  chk("out_row", out_row, e[W+3:W+2]);
                  chk("out_last", out_last, e[EXP_W-1]);
                  chk("busy", busy, 1);
                  if (out_ready) begin
                     void'(exp_q.pop_front());
                     words++;
                     exp_done = e[EXP_W-1];
                     if (words == restrike_at) start = 1'b1;
                     if (words == abort_at) abort_stage = 1;
                  end
               end
            end
         end
      end
      if (!finished) begin
         checks++;
         failures++;
         $display("FAIL timeout words=%0d expected=%0d", words, R*C);
      end
      out_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end

   initial begin
      int words, dones, done_cyc, cyc, words2;
      bit seen_done;
      logic [EXP_W-1:0] e;
      logic [W-1:0] v;

      vecs[0] = '{0, 0, 0, 0, 0, 16, 1, 17};
      vecs[1] = '{1, 0, 0, 0, 0, 16, 1, 32};
      vecs[2] = '{0, 0, 1, 0, 0, 16, 1, 17};
      vecs[3] = '{0, 0, 0, 5, 0, 16, 1, 17};
      vecs[4] = '{0, 0, 0, 0, 8, 8, 0, -1};
      vecs[5] = '{0, 0, 0, 0, 0, 16, 1, 17};
      vecs[6] = '{2, 1, 0, 0, 0, 16, 1, -1};
      vecs[7] = '{2, 1, 1, 3, 0, 16, 1, -1};

      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         run_tile(vecs[i].mode, vecs[i].rand_data, vecs[i].poison,
                  vecs[i].restrike_at, vecs[i].abort_at, words, dones, done_cyc);
         chk($sformatf("vec%0d_words", i), words, vecs[i].exp_words);
         chk($sformatf("vec%0d_dones", i), dones, vecs[i].exp_dones);
         if (vecs[i].exp_done_cyc >= 0)
            chk($sformatf("vec%0d_done_cyc", i), done_cyc, vecs[i].exp_done_cyc);
         if (vecs[i].abort_at > 0) begin
            for (int k = 0; k < 4; k++) begin
               @(negedge clk);
               chk("post_abort_done", done, 0);
               chk("post_abort_valid", out_valid, 0);
            end
         end
      end

      // 2x3 instance: indices and last flag on a non-square, non-power-of-two shape.
      exp_q.delete();
      for (int r = 0; r < R2; r++)
         for (int c = 0; c < C2; c++) begin
            v = W'($urandom);
            matrix_flat2[(r*C2+c)*W +: W] = v;
            exp_q.push_back({(r == R2-1) && (c == C2-1), 2'(r), 2'(c), v});
         end
      @(negedge clk);
      start2 = 1'b1;
      out_ready2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      chk("m2_capture_valid", out_valid2, 0);
      cyc = 0;
      words2 = 0;
      seen_done = 0;
      while (cyc < 20 && !seen_done) begin
         @(negedge clk);
         cyc++;
         chk("m2_clear_req", clear_req2, done2);
         if (done2) seen_done = 1;
         if (out_valid2) begin
            if (exp_q.size() == 0) begin
               chk("m2_extra_word", out_valid2, 0);
            end else begin
               e = exp_q.pop_front();
               words2++;
               chk("m2_data", out_data2, e[W-1:0]);
               chk("m2_col", out_col2, e[W+1:W]);
               chk("m2_row", out_row2, e[W+3:W+2]);
               chk("m2_last", out_last2, e[EXP_W-1]);
            end
         end
      end
      out_ready2 = 1'b0;
      chk("m2_words", words2, R2*C2);
      chk("m2_done_cyc", cyc, R2*C2 + 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
